// File: rtl/ofs_plat_prim_burst_resp_pkg.sv
// Shared types and helpers for merging AXI write responses when one source
// write has been split into several sink bursts.
//
// t_axi_resp   : AXI BRESP encoding.
// t_resp_accum : running merge state (worst error seen, all-EXOKAY flag).
// resp_accum_init / resp_accum_update / resp_accum_final : merge helpers.
package ofs_plat_prim_burst_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } t_axi_resp;

    typedef struct packed {
        t_axi_resp worst;
        logic      all_exokay;
    } t_resp_accum;

    function automatic t_resp_accum resp_accum_init();
        t_resp_accum a;
        a.worst      = RESP_OKAY;
        a.all_exokay = 1'b1;
        return a;
    endfunction

    // DECERR dominates SLVERR; OKAY/EXOKAY never raise the worst code, they
    // only affect whether the group stays exclusive.
    function automatic t_resp_accum resp_accum_update(t_resp_accum a, t_axi_resp code);
        t_resp_accum n;
        n = a;
        if (code == RESP_DECERR) begin
            n.worst = RESP_DECERR;
        end else if ((code == RESP_SLVERR) && (a.worst != RESP_DECERR)) begin
            n.worst = RESP_SLVERR;
        end
        n.all_exokay = a.all_exokay && (code == RESP_EXOKAY);
        return n;
    endfunction

    function automatic t_axi_resp resp_accum_final(t_resp_accum a);
        t_axi_resp r;
        if ((a.worst == RESP_DECERR) || (a.worst == RESP_SLVERR)) begin
            r = a.worst;
        end else if (a.all_exokay) begin
            r = RESP_EXOKAY;
        end else begin
            r = RESP_OKAY;
        end
        return r;
    endfunction

endpackage

// File: rtl/ofs_plat_prim_burst_split_record_fifo.sv
// Synchronous FIFO of split records (sink burst count minus one per source
// write). A pushed entry reaches the head one cycle later; there is no
// same-cycle bypass.
//
// clk, reset : clock, synchronous active-high reset
// enq_en     : push request (ignored while full)
// enq_data   : record to push
// not_full   : space available (low during the first cycle after reset)
// not_empty  : head entry valid
// head       : head record
// deq_en     : pop head
module ofs_plat_prim_burst_split_record_fifo
    import ofs_plat_prim_burst_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DEPTH      = 32
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_en,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  not_full,
    output logic                  not_empty,
    output logic [DATA_WIDTH-1:0] head,
    input  logic                  deq_en
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  init_done_q, init_done_d;
    logic                  push, pop;

    // Held low for the reset cycle so rec_ready only rises once out of reset.
    assign not_full  = init_done_q && (count_q != FULL_COUNT);
    assign not_empty = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    assign push = enq_en && not_full;
    assign pop  = deq_en && not_empty;

    always_comb begin
        init_done_d = 1'b1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_data;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(enq_en && init_done_q && (count_q == FULL_COUNT)));

endmodule

// File: rtl/ofs_plat_prim_burstcount0_write_response_merger.sv
// Collapses the N sink write responses of a split source write into one
// source write response. Split records arrive in source order from the
// gearbox; each record says how many sink responses (minus one) belong to
// the next source response. Codes are merged worst-first; metadata comes
// from the final sink response of the group.
//
// clk, reset     : clock, synchronous active-high reset
// rec_*          : split record push (valid/ready, num_splits)
// s_resp_*       : sink B channel (valid/ready, code, meta)
// m_resp_*       : merged source B channel, registered (valid/ready, code, meta)
module ofs_plat_prim_burstcount0_write_response_merger
    import ofs_plat_prim_burst_resp_pkg::*;
#(
    parameter int unsigned NUM_SPLITS_WIDTH = 4,
    parameter int unsigned TRACKER_DEPTH    = 32,
    parameter int unsigned META_WIDTH       = 8
)(
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        rec_valid,
    output logic                        rec_ready,
    input  logic [NUM_SPLITS_WIDTH-1:0] rec_num_splits,

    input  logic                        s_resp_valid,
    output logic                        s_resp_ready,
    input  logic [1:0]                  s_resp_code,
    input  logic [META_WIDTH-1:0]       s_resp_meta,

    output logic                        m_resp_valid,
    input  logic                        m_resp_ready,
    output logic [1:0]                  m_resp_code,
    output logic [META_WIDTH-1:0]       m_resp_meta
);

    logic                        head_valid;
    logic [NUM_SPLITS_WIDTH-1:0] head_num_splits;
    logic                        deq;
    logic                        out_free;
    logic                        accept;
    logic                        last_beat;

    logic [NUM_SPLITS_WIDTH-1:0] cnt_q, cnt_d;
    t_resp_accum                 acc_q, acc_d;
    t_resp_accum                 acc_next;
    logic                        m_valid_q, m_valid_d;
    t_axi_resp                   m_code_q, m_code_d;
    logic [META_WIDTH-1:0]       m_meta_q, m_meta_d;

    ofs_plat_prim_burst_split_record_fifo #(
        .DATA_WIDTH (NUM_SPLITS_WIDTH),
        .DEPTH      (TRACKER_DEPTH)
    ) record_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_en    (rec_valid),
        .enq_data  (rec_num_splits),
        .not_full  (rec_ready),
        .not_empty (head_valid),
        .head      (head_num_splits),
        .deq_en    (deq)
    );

    // The output register can take a new load if it is empty or being
    // drained this cycle, which keeps 1:1 groups at one response per cycle.
    assign out_free     = !m_valid_q || m_resp_ready;
    assign s_resp_ready = head_valid && out_free;
    assign accept       = s_resp_valid && s_resp_ready;
    assign last_beat    = (cnt_q == head_num_splits);
    assign deq          = accept && last_beat;
    assign acc_next     = resp_accum_update(acc_q, t_axi_resp'(s_resp_code));

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        m_code_d  = m_code_q;
        m_meta_d  = m_meta_q;

        if (m_valid_q && m_resp_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (last_beat) begin
                cnt_d     = '0;
                acc_d     = resp_accum_init();
                m_valid_d = 1'b1;
                m_code_d  = resp_accum_final(acc_next);
                m_meta_d  = s_resp_meta;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= resp_accum_init();
            m_valid_q <= 1'b0;
            m_code_q  <= RESP_OKAY;
            m_meta_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_code_q  <= m_code_d;
            m_meta_q  <= m_meta_d;
        end
    end

    assign m_resp_valid = m_valid_q;
    assign m_resp_code  = m_code_q;
    assign m_resp_meta  = m_meta_q;

    a_valids_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({rec_valid, s_resp_valid, m_resp_ready, m_valid_q}));

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (m_valid_q && !m_resp_ready) |=>
            (m_valid_q && $stable(m_code_q) && $stable(m_meta_q)));

endmodule

// File: doc/ofs_plat_prim_burstcount0_write_response_merger.md
Name: ofs_plat_prim_burstcount0_write_response_merger

Overview:
- Write-response side of the burst mapping gearbox.
- The gearbox splits each source write into N sink bursts; this block collapses the N sink write responses back into exactly one source response.
- Response codes are merged, and source responses are emitted in source request order.
- Sits between the sink-side AXI B channel and the source-side B channel in burst-mapping shims.

Parameters:
- NUM_SPLITS_WIDTH, 4, width of the per-request sink-command count, encoded 0-origin (0 = one sink burst).
- TRACKER_DEPTH, 32, number of outstanding source requests whose split records can be held; power of 2, at least 2.
- META_WIDTH, 8, width of pass-through response metadata (ID/user).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- rec_valid  in  1  split record valid; pushed when the gearbox completes a source request.
- rec_ready  out  1  record FIFO not full.
- rec_num_splits  in  NUM_SPLITS_WIDTH  number of sink bursts minus 1.
- s_resp_valid  in  1  sink write response valid.
- s_resp_ready  out  1  sink response accepted this cycle when both valid and ready are high.
- s_resp_code  in  2  AXI BRESP (0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR).
- s_resp_meta  in  META_WIDTH  sink response metadata.
- m_resp_valid  out  1  merged source response valid (registered).
- m_resp_ready  in  1  source consumer ready.
- m_resp_code  out  2  merged BRESP.
- m_resp_meta  out  META_WIDTH  metadata of the final sink response in the group.

Behaviour:
- Reset values: m_resp_valid=0, m_resp_code=0, m_resp_meta=0, rec_ready=0.
- Internal state on reset: FIFO empty, beat counter=0, accumulator cleared.
- rec_ready rises in the first cycle after reset deasserts.
- Reset asserted mid-operation discards all records and partial groups. Responses already in flight are the environment's responsibility.
- Record FIFO:
  - Push on rec_valid and rec_ready.
  - A record becomes visible at the head one cycle after the push, so same-cycle push-to-head bypass is not permitted.
  - rec_ready = not full. Pushes while full are ignored and asserted against in simulation.
- s_resp_ready = head record present AND (m_resp_valid==0 OR m_resp_ready==1).
- Sink responses arriving with no record at the head are back-pressured, never dropped.
- Beat counter cnt (NUM_SPLITS_WIDTH bits) counts accepted sink responses for the head record.
- On an accepted sink response with cnt != head.num_splits:
  - cnt increments.
  - Code accumulator updates.
- On an accepted sink response with cnt == head.num_splits (the final response):
  - Pop the head record and reset cnt to 0.
  - Load the output register on the same edge, giving m_resp_valid=1 the next cycle (latency 1 from the final accept).
  - m_resp_code = merge(accumulator, this code); m_resp_meta = this meta.
  - Reset the accumulator.
- num_splits=0: every sink response maps 1:1 to a source response at latency 1. Full throughput of one response per cycle is required while m_resp_ready=1.
- Code merge rule:
  - Any DECERR gives DECERR.
  - Otherwise any SLVERR gives SLVERR.
  - Otherwise all EXOKAY gives EXOKAY.
  - Otherwise OKAY.
  - Accumulator state: worst error seen (2 bits) plus an all_exokay flag initialised to 1.
- Output register:
  - Holds steady while m_resp_valid=1 and m_resp_ready=0.
  - Clears when accepted with no new load that cycle.
  - Simultaneous accept and new load: valid stays 1 and data is replaced.
- Counter width: cnt never exceeds num_splits, so there is no wrap.
- The pointer into the record FIFO wraps modulo TRACKER_DEPTH.
- Simulation assertions:
  - No unknowns on valid signals after reset.
  - m_resp_* stable while stalled.

Decomposition:
- Package ofs_plat_prim_burst_resp_pkg:
  - typedef t_axi_resp (2-bit enum).
  - typedef t_resp_accum (struct of worst code and all_exokay).
  - functions resp_accum_init, resp_accum_update, resp_accum_final.
- Sub-module ofs_plat_prim_burst_split_record_fifo:
  - Parameterised-depth synchronous FIFO with registered head, NUM_SPLITS_WIDTH data.
  - Provides not-full, not-empty, head data and deq.
- Merger top holds the counter, accumulator, output register and handshakes.

Test Plan:
- 1:1 streaming: push 8 records with num_splits=0; sink responses OKAY with meta 0..7 back-to-back; m_resp_ready=1. Expect 8 source responses on consecutive cycles, meta 0..7, code 0, each 1 cycle after its sink accept.
- 4-way split: record num_splits=3; 4 sink responses with meta 5 and codes OKAY, SLVERR, OKAY, OKAY. Expect exactly 1 source response, code 2, meta 5, valid 1 cycle after the 4th accept; s_resp_ready high throughout.
- Merge priority and EXOKAY:
  - Group 1, num_splits=1: codes EXOKAY, EXOKAY gives 1.
  - Group 2, num_splits=1: codes EXOKAY, OKAY gives 0.
  - Group 3, num_splits=2: codes SLVERR, DECERR, OKAY gives 3.
- Back-pressure: hold m_resp_ready=0 for 10 cycles with 3 single-split groups pending. Expect one valid response held stable, s_resp_ready=0 after the output register fills, then 3 responses in order once ready returns.
- Full/empty:
  - Push TRACKER_DEPTH records with no responses: rec_ready falls after the 32nd push.
  - Sink response offered while the FIFO is empty: s_resp_ready=0 until 1 cycle after the first push.
- Reset mid-group: num_splits=3, 2 responses accepted, then assert reset for 1 cycle. Expect m_resp_valid=0, FIFO empty, cnt=0; a new num_splits=0 group then completes normally.
